// File: rtl/core101_imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the NOP filler word and the latency counter width.
package core101_imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP   = 32'h00000013;
  localparam int          IMEM_CNT_W = 4;

  // Offset compare avoids the wrap-around that base+span could hit near 2^32.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction store: one write port, one registered read port.
// A read and write to the same word on the same edge returns the old word.
module imem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_in,
  input  logic                     wr_en_in,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_in,
  input  logic [31:0]              wr_data_in,
  input  logic                     rd_en_in,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_in,
  output logic [31:0]              rd_data_out
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // The read register only updates on a read, so the word holds under backpressure.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_in) rd_data_d = mem_q[rd_idx_in];
  end

  always_ff @(posedge clk_in) begin
    if (wr_en_in) mem_q[wr_idx_in] <= wr_data_in;
    rd_data_q <= rd_data_d;
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed LATENCY response.
// Define IMEM_MISALIGN_FAULT_EN to fault fetches whose address is not word aligned.
module imem_responder
  import core101_imem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
  input  logic        imem_clock_in,
  input  logic        imem_reset_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [31:0] req_addr_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_data_out,
  output logic        rsp_fault_out,
  input  logic        load_en_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in
);

  localparam int                    AW       = $clog2(DEPTH);
  localparam logic [31:0]           SPAN     = 32'(DEPTH * 4);
  localparam logic [IMEM_CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? IMEM_CNT_W'(LATENCY - 2) : '0;

  imem_state_e           state_q, state_d;
  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_fault_q, rsp_fault_d;

  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [31:0]   rd_data;
  logic          req_fault;

  assign rd_idx = AW'((addr_q - BASE_ADDR) >> 2);
  assign wr_idx = AW'((load_addr_in - BASE_ADDR) >> 2);
  assign wr_en  = load_en_in && addr_in_range(load_addr_in, BASE_ADDR, SPAN);

`ifdef IMEM_MISALIGN_FAULT_EN
  assign req_fault = !addr_in_range(addr_q, BASE_ADDR, SPAN) || (addr_q[1:0] != 2'b00);
`else
  assign req_fault = !addr_in_range(addr_q, BASE_ADDR, SPAN);
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // RESP spends its first cycle issuing the array read; valid rises on that edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rd_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          addr_d = req_addr_in;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - IMEM_CNT_W'(1);
      end
      ST_RESP: begin
        if (!rsp_valid_q) begin
          rd_en       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_fault_d = req_fault;
        end else if (rsp_ready_in) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge imem_clock_in) begin
    if (imem_reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk_in      (imem_clock_in),
    .wr_en_in    (wr_en),
    .wr_idx_in   (wr_idx),
    .wr_data_in  (load_data_in),
    .rd_en_in    (rd_en),
    .rd_idx_in   (rd_idx),
    .rd_data_out (rd_data)
  );

  assign req_ready_out = (state_q == ST_IDLE) && !imem_reset_in;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_fault_out = rsp_fault_q;
  assign rsp_data_out  = (rsp_valid_q && !rsp_fault_q) ? rd_data : IMEM_NOP;

endmodule
